// File: rtl/fixed_requant_pkg.sv
// Shared helpers for the activation requantizer: tensor framing and saturation bounds.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package fixed_requant_pkg;

    // Output beats that make up one tensor.
    function automatic int beats_per_tensor(input int t0, input int t1, input int p0, input int p1);
        return (t0 * t1) / (p0 * p1);
    endfunction

    // Largest value representable in a signed word of width w.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest value representable in a signed word of width w.
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    // Beat counter width; at least one bit so a single-beat tensor still elaborates.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/requant_skid_buffer.sv
// Two-entry valid/ready skid buffer holding one beat of width W per entry.
// Latency: 1 cycle from upstream accept to downstream valid when not stalled.
// Backpressure: up_ready is registered (skid empty, not in reset); never a function of dn_ready.
module requant_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] up_data,
    input  logic         up_valid,
    output logic         up_ready,
    output logic [W-1:0] dn_data,
    output logic         dn_valid,
    input  logic         dn_ready
);

    logic [W-1:0] main_dat;
    logic [W-1:0] skid_dat;
    logic         main_vld;
    logic         skid_vld;
    logic         up_acc;

    // Upstream may push whenever the overflow slot is free; reset blocks intake.
    assign up_ready = !skid_vld && !rst;
    assign up_acc   = up_valid && up_ready;

    assign dn_data  = main_dat;
    assign dn_valid = main_vld;

    // Main register refills on drain (skid first to keep order); a stalled main spills into skid.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dat <= '0;
            skid_dat <= '0;
        end else begin
            if (!main_vld || dn_ready) begin
                if (skid_vld) begin
                    main_dat <= skid_dat;
                    main_vld <= 1'b1;
                    skid_vld <= 1'b0;
                end else if (up_acc) begin
                    main_dat <= up_data;
                    main_vld <= 1'b1;
                end else begin
                    main_vld <= 1'b0;
                end
            end else if (up_acc) begin
                skid_dat <= up_data;
                skid_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fixed_activation_requant.sv
// Requantizes wide signed activation outputs to the next layer's format: round half up, then saturate.
// Latency: 1 cycle from input accept to output valid when downstream is ready.
// Backpressure: 2-entry skid; data_in_0_ready drops once two beats are held, registered only.
module fixed_activation_requant
    import fixed_requant_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 19,
    parameter int DATA_IN_0_PRECISION_1       = 8,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    localparam int IN_W  = DATA_IN_0_PRECISION_0,
    localparam int OUT_W = DATA_OUT_0_PRECISION_0,
    localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W*N-1:0] data_in_0,
    input  logic              data_in_0_valid,
    output logic              data_in_0_ready,
    output logic [OUT_W*N-1:0] data_out_0,
    output logic              data_out_0_valid,
    input  logic              data_out_0_ready,
    output logic              data_out_0_last,
    output logic              sat_flag,
    input  logic              sat_clear
);

    localparam int SHIFT = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1;
    localparam int EXT_W = IN_W + 1;
    localparam int BEATS = beats_per_tensor(DATA_IN_0_TENSOR_SIZE_DIM_0, DATA_IN_0_TENSOR_SIZE_DIM_1,
                                            DATA_IN_0_PARALLELISM_DIM_0, DATA_IN_0_PARALLELISM_DIM_1);
    localparam int CNT_W = cnt_width(BEATS);

    localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(sat_max(OUT_W));
    localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(sat_min(OUT_W));
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(BEATS - 1);

    // Reject configurations that cannot frame whole tensors or would need left shifts.
    if ((DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1) % N != 0) begin : g_bad_beats
        $error("tensor size is not a multiple of the lane count");
    end
    if (DATA_OUT_0_PRECISION_1 > DATA_IN_0_PRECISION_1) begin : g_bad_frac
        $error("output fraction bits exceed input fraction bits");
    end

    logic [OUT_W*N-1:0] req_dat;
    logic [N-1:0]       lane_sat;
    logic               in_acc;
    logic               out_xfer;
    logic [CNT_W-1:0]   beat_cnt;

    // Per-lane round-then-saturate; one extra integer bit keeps the rounding add from wrapping.
    for (genvar l = 0; l < N; l++) begin : g_lane
        logic signed [IN_W-1:0]  x;
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] rnd;
        logic                    hi;
        logic                    lo;

        assign x   = data_in_0[l*IN_W +: IN_W];
        assign ext = EXT_W'(x);

        if (SHIFT > 0) begin : g_round
            localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
            assign rnd = (ext + HALF) >>> SHIFT;
        end else begin : g_pass
            assign rnd = ext;
        end

        assign hi = rnd > SAT_HI;
        assign lo = rnd < SAT_LO;
        assign lane_sat[l] = hi | lo;
        assign req_dat[l*OUT_W +: OUT_W] = hi ? OUT_W'(SAT_HI) :
                                           lo ? OUT_W'(SAT_LO) : OUT_W'(rnd);
    end

    requant_skid_buffer #(
        .W(OUT_W * N)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .up_data  (req_dat),
        .up_valid (data_in_0_valid),
        .up_ready (data_in_0_ready),
        .dn_data  (data_out_0),
        .dn_valid (data_out_0_valid),
        .dn_ready (data_out_0_ready)
    );

    assign in_acc   = data_in_0_valid && data_in_0_ready;
    assign out_xfer = data_out_0_valid && data_out_0_ready;

    // Count transferred beats within the current tensor, wrapping on the final one.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (out_xfer) begin
            beat_cnt <= (beat_cnt == LAST_CNT) ? '0 : beat_cnt + CNT_W'(1);
        end
    end

    assign data_out_0_last = data_out_0_valid && (beat_cnt == LAST_CNT);

    // Sticky saturation indicator; a new clipping beat outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (in_acc && |lane_sat) begin
            sat_flag <= 1'b1;
        end else if (sat_clear) begin
            sat_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fixed_activation_requant.sv
// Directed and random bench for fixed_activation_requant with default parameters.
// Latency: n/a.
// Backpressure: bench drives both valid and ready.
module tb_fixed_activation_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] din;
    logic        in_vld;
    logic        in_rdy;
    logic [7:0]  dout;
    logic        out_vld;
    logic        out_rdy;
    logic        last;
    logic        sat;
    logic        sat_clear;

    int checks = 0;
    int errors = 0;

    fixed_activation_requant dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (din),
        .data_in_0_valid  (in_vld),
        .data_in_0_ready  (in_rdy),
        .data_out_0       (dout),
        .data_out_0_valid (out_vld),
        .data_out_0_ready (out_rdy),
        .data_out_0_last  (last),
        .sat_flag         (sat),
        .sat_clear        (sat_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: Q10.8 -> Q3.4, round half toward +inf, clamp to int8.
    function automatic logic signed [7:0] ref_rq(input logic signed [18:0] x);
        int v;
        v = (int'(x) + 8) >>> 4;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    logic signed [7:0] exp_q[$];
    logic signed [7:0] mon_e;
    logic [7:0]        prev_dat = '0;
    logic              stall_prev = 1'b0;
    int                mon_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mon_cnt    = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", int'(out_vld), 1);
                chk("hold_data", int'($signed(dout)), int'($signed(prev_dat)));
            end
            if (in_vld && in_rdy) exp_q.push_back(ref_rq(din));
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream_data", int'($signed(dout)), int'(mon_e));
                    chk("stream_last", int'(last), int'(mon_cnt == 7));
                    mon_cnt = (mon_cnt + 1) % 8;
                end
            end
            stall_prev = out_vld && !out_rdy;
            prev_dat   = dout;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic signed [18:0] din;
        logic signed [7:0]  dout;
        logic               sat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int  nxt;
        int  cyc;
        int  held;
        bit  acc;

        vecs[0]  = '{19'sd392,     8'sd25,   1'b0};
        vecs[1]  = '{-19'sd392,    -8'sd24,  1'b0};
        vecs[2]  = '{19'sd8,       8'sd1,    1'b0};
        vecs[3]  = '{-19'sd8,      8'sd0,    1'b0};
        vecs[4]  = '{19'sd2560,    8'sd127,  1'b1};
        vecs[5]  = '{-19'sd2560,   -8'sd128, 1'b1};
        vecs[6]  = '{19'sd2039,    8'sd127,  1'b0};
        vecs[7]  = '{19'sd2040,    8'sd127,  1'b1};
        vecs[8]  = '{-19'sd2048,   -8'sd128, 1'b0};
        vecs[9]  = '{-19'sd2056,   -8'sd128, 1'b0};
        vecs[10] = '{-19'sd2057,   -8'sd128, 1'b1};
        vecs[11] = '{19'sd262143,  8'sd127,  1'b1};
        vecs[12] = '{-19'sd262144, -8'sd128, 1'b1};
        vecs[13] = '{19'sd7,       8'sd0,    1'b0};

        rst = 1'b1; din = '0; in_vld = 1'b0; out_rdy = 1'b0; sat_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_rdy), 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready_after", int'(in_rdy), 1);
        chk("rst_out_valid", int'(out_vld), 0);
        chk("rst_last", int'(last), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_dout", int'(dout), 0);

        // Rounding and saturation table, one beat at a time.
        out_rdy = 1'b1;
        for (int i = 0; i < 14; i++) begin
            din = vecs[i].din;
            in_vld = 1'b1;
            @(posedge clk); #1;
            in_vld = 1'b0;
            chk("vec_valid", int'(out_vld), 1);
            chk("vec_data", int'($signed(dout)), int'(vecs[i].dout));
            chk("vec_sat", int'(sat), int'(vecs[i].sat));
            sat_clear = 1'b1;
            @(posedge clk); #1;
            sat_clear = 1'b0;
            chk("vec_sat_cleared", int'(sat), 0);
            chk("vec_drained", int'(out_vld), 0);
        end

        // Clear coinciding with a clipping beat: set wins.
        din = 19'sd2560; in_vld = 1'b1; sat_clear = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0; sat_clear = 1'b0;
        chk("sat_set_wins", int'(sat), 1);
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        chk("sat_clear_after", int'(sat), 0);

        // Streaming 16 beats from a fresh tensor boundary.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 19'(i * 37 - 200);
            in_vld = 1'b1;
            @(posedge clk); #1;
            chk("t3_in_ready", int'(in_rdy), 1);
            chk("t3_valid", int'(out_vld), 1);
            chk("t3_data", int'($signed(dout)), int'(ref_rq(19'(i * 37 - 200))));
            chk("t3_last", int'(last), int'(i == 7 || i == 15));
        end
        in_vld = 1'b0;
        @(posedge clk); #1;
        chk("t3_idle", int'(out_vld), 0);

        // Backpressure: downstream stalls 5 cycles while upstream keeps pushing.
        nxt = 0;
        for (int c = 0; c < 20; c++) begin
            out_rdy = !(c >= 4 && c < 9);
            in_vld  = 1'b1;
            din     = 19'(nxt * 100 - 700);
            acc     = in_vld && in_rdy;
            @(posedge clk); #1;
            if (acc) nxt++;
            if (c >= 4 && c < 9) begin
                chk("t4_in_ready_low", int'(in_rdy), 0);
                chk("t4_out_valid", int'(out_vld), 1);
            end
        end
        in_vld = 1'b0; out_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t4_drained", exp_q.size(), 0);

        // Random valid/ready over 1000 accepted beats.
        nxt = 0; cyc = 0;
        while (nxt < 1000 && cyc < 20000) begin
            in_vld  = 1'($urandom_range(0, 1));
            out_rdy = 1'($urandom_range(0, 1));
            din     = 19'($urandom);
            acc     = in_vld && in_rdy;
            @(posedge clk); #1;
            if (acc) nxt++;
            cyc++;
        end
        chk("t5_sent", nxt, 1000);
        in_vld = 1'b0; out_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_drained", exp_q.size(), 0);
        chk("t5_idle", int'(out_vld), 0);

        // Fill both entries, then reset: buffered beats must vanish.
        out_rdy = 1'b0; held = 0;
        for (int c = 0; c < 10 && in_rdy; c++) begin
            in_vld = 1'b1;
            din    = 19'(c * 50 + 16);
            acc    = in_vld && in_rdy;
            @(posedge clk); #1;
            if (acc) held++;
        end
        chk("t6_held", held, 2);
        chk("t6_in_ready_full", int'(in_rdy), 0);
        rst = 1'b1; in_vld = 1'b0;
        @(posedge clk); #1;
        chk("t6_rst_valid", int'(out_vld), 0);
        chk("t6_rst_last", int'(last), 0);
        chk("t6_rst_in_ready", int'(in_rdy), 0);
        chk("t6_rst_dout", int'(dout), 0);
        rst = 1'b0;
        #1;
        chk("t6_in_ready_back", int'(in_rdy), 1);
        out_rdy = 1'b1; in_vld = 1'b1; din = 19'sd392;
        @(posedge clk); #1;
        in_vld = 1'b0;
        chk("t6_first_valid", int'(out_vld), 1);
        chk("t6_first_data", int'($signed(dout)), 25);
        chk("t6_first_last", int'(last), 0);
        @(posedge clk); #1;
        chk("t6_final_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
